// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// The MEM_ARB_RR_EN build option is consumed in mem_arbiter.sv.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusyI = 2'd1,
    StBusyD = 2'd2
  } arb_state_e;

  localparam logic GntI = 1'b0;
  localparam logic GntD = 1'b1;

  localparam int unsigned DefaultTimeout = 64;
  localparam int unsigned AddrW          = 30;
  localparam int unsigned DataW          = 32;

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding datapath/memory.
interface mem_arb_if;
  import mem_arb_pkg::*;

  logic             i_req;
  logic [AddrW-1:0] i_addr;
  logic             i_ack;
  logic [DataW-1:0] i_rdata;

  logic             d_req;
  logic             d_we;
  logic [3:0]       d_be;
  logic [AddrW-1:0] d_addr;
  logic [DataW-1:0] d_wdata;
  logic             d_ack;
  logic [DataW-1:0] d_rdata;

  logic             bus_err;
  logic             to_flag;
  logic             stall;

  logic             mem_req;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [AddrW-1:0] mem_addr;
  logic [DataW-1:0] mem_wdata;
  logic [DataW-1:0] mem_rdata;
  logic             mem_ready;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_ack, i_rdata, d_ack, d_rdata, bus_err, to_flag, stall,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_ack, i_rdata, d_ack, d_rdata, bus_err, to_flag, stall,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/arb_timeout_ctr.sv
// Busy-cycle counter for the arbiter; expired_o flags the last permitted busy cycle.
module arb_timeout_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned CW    = 8,
  parameter int unsigned LIMIT = DefaultTimeout
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CW'(LIMIT - 1));

  // Saturate at the limit so a late clear is never needed for correctness.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-ported unified memory with timeout abort.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of data-over-fetch priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned CW      = 8
) (
  input logic     clock,
  input logic     reset,
  mem_arb_if.slave bus
);

  arb_state_e       state_q, state_d;
  logic             i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic             bus_err_q, bus_err_d, to_flag_q, to_flag_d;
  logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [AddrW-1:0] mem_addr_q, mem_addr_d;
  logic [DataW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DataW-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

  logic cand_i, cand_d, pick_d, start, busy, expired;

  // A requester in its ack cycle is masked so its held request is not re-granted.
  assign cand_i = bus.i_req & ~i_ack_q;
  assign cand_d = bus.d_req & ~d_ack_q;
  assign busy   = (state_q != StIdle);
  assign start  = (state_q == StIdle) & (cand_i | cand_d);

`ifdef MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  assign pick_d       = cand_d & ~(cand_i & (last_grant_q == GntD));
  assign last_grant_d = start ? (pick_d ? GntD : GntI) : last_grant_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_q <= GntI;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign pick_d = cand_d;
`endif

  arb_timeout_ctr #(
    .CW   (CW),
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk_i    (clock),
    .rst_ni   (reset),
    .clr_i    (start),
    .en_i     (busy & ~bus.mem_ready),
    .expired_o(expired)
  );

  always_comb begin
    state_d     = state_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    bus_err_d   = 1'b0;
    to_flag_d   = to_flag_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mem_req_d = 1'b1;
          if (pick_d) begin
            state_d     = StBusyD;
            mem_we_d    = bus.d_we;
            mem_be_d    = bus.d_we ? bus.d_be : 4'hF;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end else begin
            state_d     = StBusyI;
            mem_we_d    = 1'b0;
            mem_be_d    = 4'hF;
            mem_addr_d  = bus.i_addr;
            mem_wdata_d = '0;
          end
        end
      end
      StBusyI, StBusyD: begin
        // mem_ready in the limit cycle wins over the abort.
        if (bus.mem_ready || expired) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          bus_err_d = ~bus.mem_ready;
          to_flag_d = to_flag_q | ~bus.mem_ready;
          if (state_q == StBusyI) begin
            i_ack_d   = 1'b1;
            i_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = bus.mem_ready ? bus.mem_rdata : '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      to_flag_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      bus_err_q   <= bus_err_d;
      to_flag_q   <= to_flag_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.i_ack     = i_ack_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.to_flag   = to_flag_q;
  assign bus.stall     = cand_i | cand_d;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned TO = 4;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_arb_if bus ();

  mem_arbiter #(
    .TIMEOUT(TO),
    .CW     (8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Memory: word array, latency chosen per access, junk on idle cycles.
  logic [31:0] mem_arr [256];
  int   mem_mode = 0;  // 0 fixed latency, 1 never ready, 2 random latency
  int   fix_lat  = 1;
  int   acc_cyc  = 0;
  int   acc_lat  = 1;
  logic prev_req = 1'b0;
  logic rdy;

  always @(posedge clock) begin
    #1;
    if (bus.mem_req) begin
      if (!prev_req) begin
        acc_cyc = 1;
        acc_lat = (mem_mode == 2) ? int'($urandom_range(1, TO + 1)) : fix_lat;
      end else begin
        acc_cyc++;
      end
      rdy = (mem_mode != 1) && (acc_cyc == acc_lat);
      bus.mem_ready = rdy;
      bus.mem_rdata = rdy ? mem_arr[bus.mem_addr[7:0]] : $urandom;
      if (rdy && bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mem_arr[bus.mem_addr[7:0]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
      end
    end else begin
      bus.mem_ready = 1'($urandom);
      bus.mem_rdata = $urandom;
    end
    prev_req = bus.mem_req;
  end

  // Reference model: who owns the memory, how long it has been busy, what must be visible.
  int          own    = 0;  // 0 none, 1 fetch, 2 data
  int          busy_n = 0;
  logic        e_i_ack = 0, e_d_ack = 0, e_bus_err = 0, e_to_flag = 0;
  logic        e_mem_req = 0, e_mem_we = 0, last_d = 0;
  logic [3:0]  e_mem_be = 0;
  logic [29:0] e_mem_addr = 0;
  logic [31:0] e_mem_wdata = 0, e_i_rdata = 0, e_d_rdata = 0, rd;
  logic        ci, cd, take_d;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      own = 0; busy_n = 0; last_d = 0;
      e_i_ack = 0; e_d_ack = 0; e_bus_err = 0; e_to_flag = 0;
      e_mem_req = 0; e_mem_we = 0; e_mem_be = 0; e_mem_addr = 0; e_mem_wdata = 0;
      e_i_rdata = 0; e_d_rdata = 0;
    end else begin
      ci = bus.i_req && !e_i_ack;
      cd = bus.d_req && !e_d_ack;
      e_i_ack = 0; e_d_ack = 0; e_bus_err = 0;
      if (own != 0) begin
        if (bus.mem_ready || busy_n == int'(TO)) begin
          rd = bus.mem_ready ? bus.mem_rdata : 32'h0;
          if (own == 1) begin e_i_ack = 1; e_i_rdata = rd; end
          else          begin e_d_ack = 1; e_d_rdata = rd; end
          e_bus_err = !bus.mem_ready;
          if (!bus.mem_ready) e_to_flag = 1;
          e_mem_req = 0;
          own = 0;
        end else begin
          busy_n++;
        end
      end else if (ci || cd) begin
        take_d = cd && !(RR && ci && last_d);
        last_d = take_d;
        if (take_d) begin
          own = 2; e_mem_we = bus.d_we; e_mem_be = bus.d_we ? bus.d_be : 4'hF;
          e_mem_addr = bus.d_addr; e_mem_wdata = bus.d_wdata;
        end else begin
          own = 1; e_mem_we = 0; e_mem_be = 4'hF; e_mem_addr = bus.i_addr;
        end
        busy_n = 1;
        e_mem_req = 1;
      end
    end
  end

  logic cmp_en = 1'b0;
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("i_ack", 32'(bus.i_ack), 32'(e_i_ack));
      chk("d_ack", 32'(bus.d_ack), 32'(e_d_ack));
      chk("bus_err", 32'(bus.bus_err), 32'(e_bus_err));
      chk("to_flag", 32'(bus.to_flag), 32'(e_to_flag));
      chk("mem_req", 32'(bus.mem_req), 32'(e_mem_req));
      chk("stall", 32'(bus.stall),
          32'((bus.i_req && !e_i_ack) || (bus.d_req && !e_d_ack)));
      chk("i_rdata", bus.i_rdata, e_i_rdata);
      chk("d_rdata", bus.d_rdata, e_d_rdata);
      if (e_mem_req) begin
        chk("mem_addr", 32'(bus.mem_addr), 32'(e_mem_addr));
        chk("mem_we", 32'(bus.mem_we), 32'(e_mem_we));
        chk("mem_be", 32'(bus.mem_be), 32'(e_mem_be));
        if (e_mem_we) chk("mem_wdata", bus.mem_wdata, e_mem_wdata);
      end
    end
  end

  int ack_pos[$];

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
    mem_arr[4] = 32'h2008_0005;
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_be = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_ready = 0; bus.mem_rdata = 0;

    // Reset values
    tick(); tick();
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_be", 32'(bus.mem_be), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_acks", 32'({bus.i_ack, bus.d_ack, bus.bus_err, bus.to_flag}), 0);
    chk("rst_rdata", bus.i_rdata | bus.d_rdata, 0);
    reset = 1;
    cmp_en = 1;

    // Single fetch, memory ready in first busy cycle
    mem_mode = 0; fix_lat = 1;
    tick(); bus.i_req = 1; bus.i_addr = 30'h4;
    tick();
    chk("t1_mem_req", 32'(bus.mem_req), 1);
    chk("t1_mem_be", 32'(bus.mem_be), 32'hF);
    chk("t1_stall", 32'(bus.stall), 1);
    tick();
    chk("t1_i_ack", 32'(bus.i_ack), 1);
    chk("t1_i_rdata", bus.i_rdata, 32'h2008_0005);
    chk("t1_mem_req_off", 32'(bus.mem_req), 0);
    chk("t1_stall_off", 32'(bus.stall), 0);
    bus.i_req = 0;
    tick();

    // Simultaneous requests: store first, fetch granted in the d_ack cycle
    bus.i_req = 1; bus.i_addr = 30'h8;
    bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0001; bus.d_addr = 30'h10; bus.d_wdata = 32'hFF;
    tick();
    chk("t2_mem_we", 32'(bus.mem_we), 1);
    chk("t2_mem_be", 32'(bus.mem_be), 32'h1);
    chk("t2_mem_addr", 32'(bus.mem_addr), 32'h10);
    tick();
    chk("t2_d_ack", 32'(bus.d_ack), 1);
    bus.d_req = 0;
    tick();
    chk("t2_fetch_req", 32'(bus.mem_req), 1);
    chk("t2_fetch_addr", 32'(bus.mem_addr), 32'h8);
    tick();
    chk("t2_i_ack", 32'(bus.i_ack), 1);
    bus.i_req = 0;
    tick();

    // Memory ready exactly in the limit cycle: normal completion
    fix_lat = TO;
    bus.i_req = 1; bus.i_addr = 30'h4;
    repeat (TO + 1) tick();
    chk("t4_i_ack", 32'(bus.i_ack), 1);
    chk("t4_bus_err", 32'(bus.bus_err), 0);
    chk("t4_to_flag", 32'(bus.to_flag), 0);
    chk("t4_i_rdata", bus.i_rdata, 32'h2008_0005);
    bus.i_req = 0;
    tick();

    // Hung memory: abort after TO busy cycles
    mem_mode = 1;
    bus.i_req = 1;
    repeat (TO) tick();
    chk("t3_no_ack_yet", 32'(bus.i_ack), 0);
    tick();
    chk("t3_i_ack", 32'(bus.i_ack), 1);
    chk("t3_bus_err", 32'(bus.bus_err), 1);
    chk("t3_i_rdata", bus.i_rdata, 0);
    bus.i_req = 0; mem_mode = 0; fix_lat = 1;
    tick();
    chk("t3_to_sticky", 32'(bus.to_flag), 1);
    chk("t3_err_pulse", 32'(bus.bus_err), 0);

    // Asynchronous reset in the middle of a data access
    mem_mode = 1;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 30'h4;
    tick(); tick();
    reset = 0;
    #1;
    chk("t5_mem_req", 32'(bus.mem_req), 0);
    chk("t5_d_ack", 32'(bus.d_ack), 0);
    chk("t5_to_flag", 32'(bus.to_flag), 0);
    tick();
    reset = 1; mem_mode = 0; fix_lat = 1;
    tick(); tick();
    chk("t5_fresh_ack", 32'(bus.d_ack), 1);
    chk("t5_fresh_data", bus.d_rdata, 32'h2008_0005);
    bus.d_req = 0;
    tick();

    // Back-to-back loads with 2-cycle memory
    fix_lat = 2;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 30'h8;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (bus.d_ack) begin
        ack_pos.push_back(c);
        chk("t6_idle_in_ack", 32'(bus.mem_req), 0);
      end
    end
    bus.d_req = 0;
    chk("t6_ack_count", 32'(ack_pos.size()), 3);
    if (ack_pos.size() == 3) begin
      chk("t6_ack0", 32'(ack_pos[0]), 3);
      chk("t6_ack1", 32'(ack_pos[1]), 7);
      chk("t6_ack2", 32'(ack_pos[2]), 11);
    end
    repeat (8) tick();

    // Random traffic with random latency, including timeouts
    mem_mode = 2;
    repeat (3000) begin
      tick();
      if (bus.i_req) begin
        if (bus.i_ack) begin
          if ($urandom_range(0, 1) == 0) bus.i_req = 0;
          else bus.i_addr = 30'($urandom_range(0, 255));
        end
      end else if ($urandom_range(0, 2) == 0) begin
        bus.i_req = 1; bus.i_addr = 30'($urandom_range(0, 255));
      end
      if (bus.d_req) begin
        if (bus.d_ack && $urandom_range(0, 1) == 0) bus.d_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.d_req = 1; bus.d_we = 1'($urandom); bus.d_be = 4'($urandom);
        bus.d_addr = 30'($urandom_range(0, 255)); bus.d_wdata = $urandom;
      end
    end
    bus.i_req = 0; bus.d_req = 0;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
